// File: rtl/ervp_memory_stream_reader.sv
// Streams {base,count} reads from a 1-cycle-latency memory as valid/ready beats.
// Optional per-command index stride: ERVP_MEMORY_STREAM_READER_STRIDE_EN.
module ervp_memory_stream_reader #(
   parameter int DEPTH    = 16,
   parameter int WIDTH    = 32,
   parameter int BW_INDEX = 4,
   parameter int BW_COUNT = BW_INDEX + 1
) (
   input  logic                clk,
   input  logic                rstnn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [BW_INDEX-1:0] cmd_base,
   input  logic [BW_COUNT-1:0] cmd_count,
`ifdef ERVP_MEMORY_STREAM_READER_STRIDE_EN
   input  logic [BW_INDEX-1:0] cmd_stride,
`endif
   output logic [BW_INDEX-1:0] mem_rindex,
   output logic                mem_renable,
   input  logic [WIDTH-1:0]    mem_rdata_synch,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic [WIDTH-1:0]    tx_data,
   output logic                tx_last,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE0
   } state_t;

   localparam logic [BW_INDEX:0] DEPTH_L = (BW_INDEX+1)'(DEPTH);

   state_t              state;
   logic [BW_COUNT-1:0] cnt_q;
   logic [BW_COUNT-1:0] issued;
   logic [BW_COUNT-1:0] delivered;
   logic [BW_INDEX-1:0] idx;
   logic [BW_INDEX-1:0] step;
   logic [BW_INDEX-1:0] idx_next;
   logic [BW_INDEX:0]   sum;
   logic [BW_INDEX:0]   wrap1;
   logic                inflight;
   logic [1:0]          occ;
   logic [WIDTH-1:0]    buf0;
   logic [WIDTH-1:0]    buf1;
   logic                pop;
   logic                push;
   logic                last_issue;
   logic [2:0]          room;

`ifdef ERVP_MEMORY_STREAM_READER_STRIDE_EN
   logic [BW_INDEX-1:0] stride_q;
   assign step = stride_q;
`else
   assign step = BW_INDEX'(1);
`endif

   // wrap by compare so non-power-of-two depths step correctly
   assign sum      = {1'b0, idx} + {1'b0, step};
   assign wrap1    = (sum >= DEPTH_L) ? sum - DEPTH_L : sum;
   assign idx_next = BW_INDEX'((wrap1 >= DEPTH_L) ? wrap1 - DEPTH_L : wrap1);

   assign pop        = tx_valid & tx_ready;
   assign push       = inflight;
   assign room       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign last_issue = (issued == cnt_q - BW_COUNT'(1));

   assign mem_renable = (state == S_READ) && (issued != cnt_q)
                        && (room < 3'd2);
   assign mem_rindex  = idx;
   assign cmd_ready   = (state == S_IDLE);
   assign busy        = (state != S_IDLE);
   assign tx_valid    = (occ != 2'd0);
   assign tx_data     = buf0;
   assign tx_last     = tx_valid && (delivered == cnt_q - BW_COUNT'(1));

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state     <= S_IDLE;
         cnt_q     <= '0;
         issued    <= '0;
         delivered <= '0;
         idx       <= '0;
         done      <= 1'b0;
`ifdef ERVP_MEMORY_STREAM_READER_STRIDE_EN
         stride_q  <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (pop)
            delivered <= delivered + BW_COUNT'(1);
         unique case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  cnt_q     <= cmd_count;
                  idx       <= cmd_base;
                  issued    <= '0;
                  delivered <= '0;
`ifdef ERVP_MEMORY_STREAM_READER_STRIDE_EN
                  stride_q  <= cmd_stride;
`endif
                  if (cmd_count == '0) begin
                     state <= S_DONE0;
                     done  <= 1'b1;
                  end else begin
                     state <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (mem_renable) begin
                  issued <= issued + BW_COUNT'(1);
                  // keep the final index visible after the last read
                  if (last_issue)
                     state <= S_DRAIN;
                  else
                     idx <= idx_next;
               end
            end
            S_DRAIN: begin
               if (pop && tx_last) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            S_DONE0: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         inflight <= 1'b0;
         occ      <= 2'd0;
         buf0     <= '0;
         buf1     <= '0;
      end else begin
         inflight <= mem_renable;
         unique case ({push, pop})
            2'b10: begin
               if (occ == 2'd0)
                  buf0 <= mem_rdata_synch;
               else
                  buf1 <= mem_rdata_synch;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               buf0 <= buf1;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  buf0 <= mem_rdata_synch;
               end else begin
                  buf0 <= buf1;
                  buf1 <= mem_rdata_synch;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ervp_memory_stream_reader.sv
// Scoreboard bench for ervp_memory_stream_reader (DEPTH=16 and DEPTH=12).
// Build with ERVP_MEMORY_STREAM_READER_STRIDE_EN to also cover the stride step.
module tb_ervp_memory_stream_reader;

   localparam int DEPTH    = 16;
   localparam int WIDTH    = 32;
   localparam int BW_INDEX = 4;
   localparam int BW_COUNT = 5;

   logic                clk = 1'b0;
   logic                rstnn;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [BW_INDEX-1:0] cmd_base;
   logic [BW_COUNT-1:0] cmd_count;
   logic [BW_INDEX-1:0] cmd_stride;
   logic [BW_INDEX-1:0] mem_rindex;
   logic                mem_renable;
   logic [WIDTH-1:0]    mem_rdata_synch;
   logic                tx_valid;
   logic                tx_ready;
   logic [WIDTH-1:0]    tx_data;
   logic                tx_last;
   logic                busy;
   logic                done;

   logic                b_cmd_valid;
   logic                b_cmd_ready;
   logic [BW_INDEX-1:0] b_cmd_base;
   logic [BW_COUNT-1:0] b_cmd_count;
   logic [BW_INDEX-1:0] b_cmd_stride;
   logic [BW_INDEX-1:0] b_rindex;
   logic                b_renable;
   logic [WIDTH-1:0]    b_rdata;
   logic                b_tx_valid;
   logic [WIDTH-1:0]    b_tx_data;
   logic                b_tx_last;
   logic                b_busy;
   logic                b_done;

   logic [WIDTH-1:0] mem   [DEPTH];
   logic [WIDTH-1:0] mem12 [12];

   logic [WIDTH-1:0] exp_data [$];
   logic             exp_last [$];
   int               exp_idx  [$];

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int beats = 0;
   int last_cyc = -1;
   bit rdy_rand = 1'b0;

   always #5 clk = ~clk;

   ervp_memory_stream_reader #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .BW_INDEX(BW_INDEX), .BW_COUNT(BW_COUNT)
   ) dut (
      .clk(clk), .rstnn(rstnn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base(cmd_base), .cmd_count(cmd_count),
`ifdef ERVP_MEMORY_STREAM_READER_STRIDE_EN
      .cmd_stride(cmd_stride),
`endif
      .mem_rindex(mem_rindex), .mem_renable(mem_renable),
      .mem_rdata_synch(mem_rdata_synch),
      .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx_last(tx_last),
      .busy(busy), .done(done)
   );

   ervp_memory_stream_reader #(
      .DEPTH(12), .WIDTH(WIDTH), .BW_INDEX(BW_INDEX), .BW_COUNT(BW_COUNT)
   ) dut12 (
      .clk(clk), .rstnn(rstnn),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_base(b_cmd_base), .cmd_count(b_cmd_count),
`ifdef ERVP_MEMORY_STREAM_READER_STRIDE_EN
      .cmd_stride(b_cmd_stride),
`endif
      .mem_rindex(b_rindex), .mem_renable(b_renable),
      .mem_rdata_synch(b_rdata),
      .tx_valid(b_tx_valid), .tx_ready(1'b1),
      .tx_data(b_tx_data), .tx_last(b_tx_last),
      .busy(b_busy), .done(b_done)
   );

   always @(posedge clk) begin
      if (mem_renable) mem_rdata_synch <= mem[mem_rindex];
      if (b_renable)   b_rdata <= mem12[b_rindex];
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // stream monitor: index order, beat order, stability, occupancy bound
   initial begin
      int iss_n;
      int pop_n;
      bit prev_stall;
      logic [WIDTH-1:0] prev_data;
      iss_n = 0;
      pop_n = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (!rstnn) begin
            iss_n = 0;
            pop_n = 0;
            prev_stall = 1'b0;
         end else begin
            if (iss_n - pop_n > 2)
               check("occ_inflight", 64'(iss_n - pop_n), 2);
            if (mem_renable) begin
               check("rindex_expected", 64'(exp_idx.size() != 0), 1);
               if (exp_idx.size() != 0)
                  check("rindex", 64'(mem_rindex), 64'(exp_idx.pop_front()));
               iss_n++;
            end
            if (prev_stall) begin
               check("hold_valid", 64'(tx_valid), 1);
               check("hold_data", 64'(tx_data), 64'(prev_data));
            end
            if (tx_valid && tx_ready) begin
               check("beat_expected", 64'(exp_data.size() != 0), 1);
               if (exp_data.size() != 0) begin
                  check("tx_data", 64'(tx_data), 64'(exp_data.pop_front()));
                  check("tx_last", 64'(tx_last), 64'(exp_last.pop_front()));
               end
               beats++;
               pop_n++;
               if (tx_last) last_cyc = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
         end
      end
   end

   // drive a command at a negedge; returns at the negedge of T+1
   task automatic send(input int base, input int count, input int stride);
      int k;
      int idx;
      k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("cmd_ready_wait", 64'(cmd_ready), 1);
      cmd_valid  = 1'b1;
      cmd_base   = BW_INDEX'(base);
      cmd_count  = BW_COUNT'(count);
      cmd_stride = BW_INDEX'(stride);
      idx = base;
      for (int i = 0; i < count; i++) begin
         exp_idx.push_back(idx);
         exp_data.push_back(mem[idx]);
         exp_last.push_back(i == count - 1);
         idx = (idx + stride) % DEPTH;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(output int dcyc);
      int k;
      k = 0;
      dcyc = -1;
      while (k < 300 && dcyc < 0) begin
         @(negedge clk);
         if (done) dcyc = cyc;
         k++;
      end
      check("done_seen", 64'(dcyc >= 0), 1);
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_q"}, 64'(exp_data.size() + exp_idx.size()), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 1);
      check({tag, "_renable"}, 64'(mem_renable), 0);
      check({tag, "_rindex"}, 64'(mem_rindex), 0);
      check({tag, "_tx_valid"}, 64'(tx_valid), 0);
      check({tag, "_tx_data"}, 64'(tx_data), 0);
      check({tag, "_tx_last"}, 64'(tx_last), 0);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_done"}, 64'(done), 0);
   endtask

   initial begin
      int t1;
      int dc;
      int k;
      int b0;
      bit seen;
      for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i * 'h11);
      for (int i = 0; i < 12; i++) mem12[i] = WIDTH'('h100 + i * 'h11);
      rstnn = 1'b0;
      cmd_valid = 1'b0;
      cmd_base = '0;
      cmd_count = '0;
      cmd_stride = '0;
      tx_ready = 1'b1;
      b_cmd_valid = 1'b0;
      b_cmd_base = '0;
      b_cmd_count = '0;
      b_cmd_stride = BW_INDEX'(1);
      #12;
      check_reset_outputs("rst");
      @(negedge clk);
      rstnn = 1'b1;

      // basic: base=2 count=4, full rate
      send(2, 4, 1);
      t1 = cyc;
      check("t1_renable", 64'(mem_renable), 1);
      check("t1_busy", 64'(busy), 1);
      check("t1_cmd_ready", 64'(cmd_ready), 0);
      check("t1_tx_valid", 64'(tx_valid), 0);
      @(negedge clk);
      check("t2_tx_valid", 64'(tx_valid), 0);
      @(negedge clk);
      check("t3_tx_valid", 64'(tx_valid), 1);
      check("t3_tx_data", 64'(tx_data), 'h22);
      wait_done(dc);
      check("done_latency", 64'(dc - t1), 6);
      check("done_after_last", 64'(dc - last_cyc), 1);
      check("done_cmd_ready", 64'(cmd_ready), 1);
      @(negedge clk);
      check("post_done", 64'(done), 0);
      check("post_busy", 64'(busy), 0);
      check_empty("basic");

      // wrap: 14,15,0,1
      send(14, 4, 1);
      wait_done(dc);
      check_empty("wrap");

      // backpressure
      rdy_rand = 1'b1;
      b0 = beats;
      send(3, 8, 1);
      wait_done(dc);
      check("bp_beats", 64'(beats - b0), 8);
      check_empty("bp");
      rdy_rand = 1'b0;

      // full-depth command with backpressure
      rdy_rand = 1'b1;
      send(9, 16, 1);
      wait_done(dc);
      check_empty("full");
      rdy_rand = 1'b0;

      // zero length
      send(5, 0, 1);
      check("z1_done", 64'(done), 1);
      check("z1_cmd_ready", 64'(cmd_ready), 0);
      check("z1_tx_valid", 64'(tx_valid), 0);
      @(negedge clk);
      check("z2_done", 64'(done), 0);
      check("z2_cmd_ready", 64'(cmd_ready), 1);
      check_empty("zero");

      // reset after 2 of 6 beats
      b0 = beats;
      send(0, 6, 1);
      k = 0;
      while (beats < b0 + 2 && k < 100) begin
         @(posedge clk);
         #2;
         k++;
      end
      check("mid_beats", 64'(beats - b0), 2);
      rstnn = 1'b0;
      #1;
      check_reset_outputs("mid");
      exp_data.delete();
      exp_last.delete();
      exp_idx.delete();
      @(negedge clk);
      @(negedge clk);
      rstnn = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done || tx_valid || mem_renable) seen = 1'b1;
      end
      check("mid_quiet", 64'(seen), 0);
      send(9, 3, 1);
      wait_done(dc);
      check_empty("after_rst");

`ifdef ERVP_MEMORY_STREAM_READER_STRIDE_EN
      send(1, 4, 5);
      wait_done(dc);
      check_empty("stride");
      send(7, 3, 0);
      wait_done(dc);
      check_empty("stride0");
`endif

      // DEPTH=12 wrap: 11 then 0
      @(negedge clk);
      b_cmd_valid = 1'b1;
      b_cmd_base  = BW_INDEX'(11);
      b_cmd_count = BW_COUNT'(2);
      @(negedge clk);
      b_cmd_valid = 1'b0;
      check("d12_t1_renable", 64'(b_renable), 1);
      check("d12_t1_rindex", 64'(b_rindex), 11);
      @(negedge clk);
      check("d12_t2_renable", 64'(b_renable), 1);
      check("d12_t2_rindex", 64'(b_rindex), 0);
      @(negedge clk);
      check("d12_t3_data", 64'(b_tx_data), 64'(mem12[11]));
      check("d12_t3_last", 64'(b_tx_last), 0);
      @(negedge clk);
      check("d12_t4_data", 64'(b_tx_data), 64'(mem12[0]));
      check("d12_t4_last", 64'(b_tx_last), 1);
      @(negedge clk);
      check("d12_done", 64'(b_done), 1);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
